dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester datamemory arbiter.
// Requester 0 is the CPU and requester 1 is the loader/DMA.
package dmem_arbiter_pkg;

  localparam int NUM_REQ        = 2;
  localparam int DEF_BITNESS    = 32;
  localparam int DEF_CTRL_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and loader/DMA access to a single-port datamemory.
// Ownership alternates per transaction unless the owner locks, bounded by MAX_HOLD.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int BITNESS    = DEF_BITNESS,
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int MAX_HOLD   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  input  logic [NUM_REQ*BITNESS-1:0]    addr_i,
  input  logic [NUM_REQ*BITNESS-1:0]    wdata_i,
  input  logic [NUM_REQ*CTRL_WIDTH-1:0] ctrl_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [BITNESS-1:0]            rdata_o,
  output logic [BITNESS-1:0]            mem_addr_o,
  output logic [BITNESS-1:0]            mem_wdata_o,
  output logic                          mem_we_o,
  output logic [CTRL_WIDTH-1:0]         mem_ctrl_o,
  input  logic [BITNESS-1:0]            mem_rdata_i,
  output arb_state_t                    dbg_state_o
);

  // Handshake: a requester holds req_i with its addr/wdata/ctrl/we stable; the
  // transaction completes in any cycle where its gnt_o bit is 1 (gnt_o acts as
  // ready). A granted load returns rvalid_o/rdata_o exactly one cycle later.

  localparam int              HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  arb_state_t          state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [BITNESS-1:0]  rdata_q, rdata_d;

  logic       owned;
  logic       owner;
  logic       own_req;
  logic       oth_req;
  logic       own_lock;
  arb_state_t other_st;

  always_comb begin
    owned    = (state_q != IDLE);
    owner    = (state_q == OWN1);
    own_req  = owner ? req_i[1]  : req_i[0];
    oth_req  = owner ? req_i[0]  : req_i[1];
    own_lock = owner ? lock_i[1] : lock_i[0];
    other_st = owner ? OWN0 : OWN1;
  end

  // Memory-side mux: all outputs are forced to zero while idle.
  always_comb begin
    gnt_o       = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_ctrl_o  = '0;
    if (owned) begin
      if (owner) begin
        gnt_o       = {req_i[1], 1'b0};
        mem_addr_o  = addr_i[2*BITNESS-1:BITNESS];
        mem_wdata_o = wdata_i[2*BITNESS-1:BITNESS];
        mem_ctrl_o  = ctrl_i[2*CTRL_WIDTH-1:CTRL_WIDTH];
      end else begin
        gnt_o       = {1'b0, req_i[0]};
        mem_addr_o  = addr_i[BITNESS-1:0];
        mem_wdata_o = wdata_i[BITNESS-1:0];
        mem_ctrl_o  = ctrl_i[CTRL_WIDTH-1:0];
      end
    end
    mem_we_o = |(gnt_o & we_i);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_i == 2'b11) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (req_i[0]) begin
          state_d = OWN0;
        end else if (req_i[1]) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_d = oth_req ? other_st : IDLE;
        end else if (oth_req && (!own_lock || (hold_cnt_q == HOLD_MAX))) begin
          state_d = other_st;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold counter only advances on granted cycles that keep the same owner.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if (owned && own_req && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end

    last_owner_d = last_owner_q;
    if (state_d == OWN0) begin
      last_owner_d = 1'b0;
    end else if (state_d == OWN1) begin
      last_owner_d = 1'b1;
    end

    rvalid_d = gnt_o & ~we_i;
    rdata_d  = (|rvalid_d) ? mem_rdata_i : rdata_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: grant sequencing, lock bound, handover, reset abort,
// and load data returned through an expected-value queue.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int CW = 3;
  localparam int MH = 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [1:0]        req_i, we_i, lock_i;
  logic [2*W-1:0]    addr_i, wdata_i;
  logic [2*CW-1:0]   ctrl_i;
  logic [1:0]        gnt_o, rvalid_o;
  logic [W-1:0]      rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic              mem_we_o;
  logic [CW-1:0]     mem_ctrl_o;
  arb_state_t        dbg_state_o;

  logic [W-1:0]      mem     [0:63];
  logic [W-1:0]      ref_mem [0:63];
  logic [W+1:0]      exp_q[$];
  logic [W+1:0]      mon_e;
  int                n_checks = 0;
  int                n_errors = 0;

  dmem_arbiter #(.BITNESS(W), .CTRL_WIDTH(CW), .MAX_HOLD(MH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .lock_i      (lock_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ctrl_i      (ctrl_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .mem_ctrl_o  (mem_ctrl_o),
    .mem_rdata_i (mem_rdata_i),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o[7:2]];

  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
  end

  // ---------------- load-data scoreboard ----------------
  always @(negedge clk) begin
    if (rvalid_o !== 2'b00) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_rvalid: got rvalid=%b rdata=%h, want no rvalid", rvalid_o, rdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rvalid_o, rdata_o} !== mon_e) begin
          n_errors++;
          $display("FAIL load_data: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                   rvalid_o, rdata_o, mon_e[W+1:W], mon_e[W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input logic req, input logic we, input logic lock,
                       input logic [W-1:0] a, input logic [W-1:0] d, input logic [CW-1:0] c);
    if (k == 0) begin
      req_i[0] = req; we_i[0] = we; lock_i[0] = lock;
      addr_i[W-1:0] = a; wdata_i[W-1:0] = d; ctrl_i[CW-1:0] = c;
    end else begin
      req_i[1] = req; we_i[1] = we; lock_i[1] = lock;
      addr_i[2*W-1:W] = a; wdata_i[2*W-1:W] = d; ctrl_i[2*CW-1:CW] = c;
    end
  endtask

  task automatic idle_inputs();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Leaves the bench at the first cycle after reset release.
  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h55, 3'b010);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h48, 32'h66, 3'b010);
    tick();
    mid();
    n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
    n_checks++; if (rvalid_o !== 2'b00) begin n_errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid_o); end
    n_checks++; if (rdata_o !== '0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    n_checks++; if (dbg_state_o !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state_o, IDLE); end
    n_checks++; if (mem_addr_o !== '0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
  endtask

  task automatic test_alternate();
    logic [1:0]   exp_g;
    logic [W-1:0] exp_a;
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b0, 32'hC0, 32'hA0A0_0000, 3'b010);
    drive(1, 1'b1, 1'b1, 1'b0, 32'hC4, 32'hB0B0_0000, 3'b010);
    mid();
    n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL alt_c0_gnt: got %b want 00", gnt_o); end
    for (int c = 1; c <= 6; c++) begin
      tick();
      mid();
      exp_g = (c % 2 == 1) ? 2'b01 : 2'b10;
      exp_a = (c % 2 == 1) ? 32'hC0 : 32'hC4;
      n_checks++; if (gnt_o !== exp_g) begin n_errors++; $display("FAIL alt_gnt c%0d: got %b want %b", c, gnt_o, exp_g); end
      n_checks++; if (mem_addr_o !== exp_a) begin n_errors++; $display("FAIL alt_addr c%0d: got %h want %h", c, mem_addr_o, exp_a); end
      n_checks++; if (mem_we_o !== 1'b1) begin n_errors++; $display("FAIL alt_we c%0d: got %b want 1", c, mem_we_o); end
    end
  endtask

  task automatic test_store_load();
    do_reset();
    drive(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 3'b010);
    mid();
    tick();
    mid();
    n_checks++; if (gnt_o !== 2'b10) begin n_errors++; $display("FAIL sl_store_gnt: got %b want 10", gnt_o); end
    n_checks++; if (mem_we_o !== 1'b1) begin n_errors++; $display("FAIL sl_store_we: got %b want 1", mem_we_o); end
    n_checks++; if (mem_wdata_o !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL sl_wdata: got %h want deadbeef", mem_wdata_o); end
    n_checks++; if (mem_ctrl_o !== 3'b010) begin n_errors++; $display("FAIL sl_ctrl: got %b want 010", mem_ctrl_o); end
    ref_mem[4] = 32'hDEAD_BEEF;
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 3'b010);
    mid();
    n_checks++; if (gnt_o !== 2'b10) begin n_errors++; $display("FAIL sl_load_gnt: got %b want 10", gnt_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_errors++; $display("FAIL sl_load_we: got %b want 0", mem_we_o); end
    n_checks++; if (rvalid_o !== 2'b00) begin n_errors++; $display("FAIL sl_store_rvalid: got %b want 00", rvalid_o); end
    exp_q.push_back({2'b10, 32'hDEAD_BEEF});
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 3'b010);
    mid();
    tick();
    mid();
    n_checks++; if (rvalid_o !== 2'b00) begin n_errors++; $display("FAIL sl_rvalid_once: got %b want 00", rvalid_o); end
    n_checks++; if (rdata_o !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL sl_rdata_hold: got %h want deadbeef", rdata_o); end
  endtask

  task automatic test_lock();
    logic [1:0] exp_g;
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b1, 32'hC0, 32'h0101_0101, 3'b010);
    drive(1, 1'b1, 1'b1, 1'b0, 32'hC4, 32'h0202_0202, 3'b010);
    mid();
    for (int c = 1; c <= MH + 2; c++) begin
      tick();
      mid();
      exp_g = (c == MH + 1) ? 2'b10 : 2'b01;
      n_checks++; if (gnt_o !== exp_g) begin n_errors++; $display("FAIL lock_gnt c%0d: got %b want %b", c, gnt_o, exp_g); end
    end
  endtask

  task automatic test_handover();
    do_reset();
    drive(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h1111_1111, 3'b010);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h2222_2222, 3'b101);
    mid();
    tick();
    mid();
    n_checks++; if (gnt_o !== 2'b01) begin n_errors++; $display("FAIL ho_first_gnt: got %b want 01", gnt_o); end
    exp_q.push_back({2'b01, ref_mem[16]});
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h1111_1111, 3'b010);
    mid();
    n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL ho_drop_gnt: got %b want 00", gnt_o); end
    n_checks++; if (dbg_state_o !== OWN0) begin n_errors++; $display("FAIL ho_drop_state: got %0d want %0d", dbg_state_o, OWN0); end
    tick();
    mid();
    n_checks++; if (gnt_o !== 2'b10) begin n_errors++; $display("FAIL ho_switch_gnt: got %b want 10", gnt_o); end
    n_checks++; if (dbg_state_o !== OWN1) begin n_errors++; $display("FAIL ho_switch_state: got %0d want %0d", dbg_state_o, OWN1); end
    exp_q.push_back({2'b10, ref_mem[32]});
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h2222_2222, 3'b101);
    mid();
    tick();
    mid();
    n_checks++; if (dbg_state_o !== IDLE) begin n_errors++; $display("FAIL ho_idle_state: got %0d want %0d", dbg_state_o, IDLE); end
    n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL ho_idle_gnt: got %b want 00", gnt_o); end
    n_checks++; if (mem_addr_o !== '0) begin n_errors++; $display("FAIL ho_idle_addr: got %h want 0", mem_addr_o); end
    n_checks++; if (mem_wdata_o !== '0) begin n_errors++; $display("FAIL ho_idle_wdata: got %h want 0", mem_wdata_o); end
    n_checks++; if (mem_ctrl_o !== '0) begin n_errors++; $display("FAIL ho_idle_ctrl: got %b want 0", mem_ctrl_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_errors++; $display("FAIL ho_idle_we: got %b want 0", mem_we_o); end
  endtask

  task automatic test_random_rw();
    int           idx;
    logic         we;
    logic [W-1:0] a, d;
    logic [CW-1:0] c;
    do_reset();
    for (int t = 0; t < 20; t++) begin
      idx = $urandom_range(0, 15);
      we  = 1'($urandom_range(0, 1));
      d   = $urandom;
      c   = CW'($urandom_range(0, 7));
      a   = W'(idx) << 2;
      drive(0, 1'b1, we, 1'b0, a, d, c);
      if (t == 0) begin
        mid();
        tick();
      end
      mid();
      n_checks++; if (gnt_o !== 2'b01) begin n_errors++; $display("FAIL rw_gnt t%0d: got %b want 01", t, gnt_o); end
      n_checks++; if (mem_addr_o !== a) begin n_errors++; $display("FAIL rw_addr t%0d: got %h want %h", t, mem_addr_o, a); end
      n_checks++; if (mem_ctrl_o !== c) begin n_errors++; $display("FAIL rw_ctrl t%0d: got %b want %b", t, mem_ctrl_o, c); end
      n_checks++; if (mem_we_o !== we) begin n_errors++; $display("FAIL rw_we t%0d: got %b want %b", t, mem_we_o, we); end
      if (we) ref_mem[idx] = d;
      else    exp_q.push_back({2'b01, ref_mem[idx]});
      tick();
    end
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    mid();
    tick();
    mid();
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h1234_5678, 3'b010);
    mid();
    tick();
    mid();
    n_checks++; if (gnt_o !== 2'b01) begin n_errors++; $display("FAIL rms_gnt: got %b want 01", gnt_o); end
    n_checks++; if (mem_we_o !== 1'b1) begin n_errors++; $display("FAIL rms_we: got %b want 1", mem_we_o); end
    #1;
    rst_i = 1'b1;
    #1;
    n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL rms_async_gnt: got %b want 00", gnt_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_errors++; $display("FAIL rms_async_we: got %b want 0", mem_we_o); end
    n_checks++; if (dbg_state_o !== IDLE) begin n_errors++; $display("FAIL rms_async_state: got %0d want %0d", dbg_state_o, IDLE); end
    tick();
    n_checks++; if (mem[8] !== ref_mem[8]) begin n_errors++; $display("FAIL rms_no_write: got %h want %h", mem[8], ref_mem[8]); end
    rst_i = 1'b0;
    mid();
    n_checks++; if (gnt_o !== 2'b00) begin n_errors++; $display("FAIL rms_release_gnt: got %b want 00", gnt_o); end
    tick();
    mid();
    n_checks++; if (gnt_o !== 2'b01) begin n_errors++; $display("FAIL rms_regrant: got %b want 01", gnt_o); end
    ref_mem[8] = 32'h1234_5678;
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    mid();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    logic [W-1:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    test_reset();
    test_alternate();
    test_store_load();
    test_lock();
    test_handover();
    test_random_rw();
    test_reset_mid_store();
    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_loads: got %0d outstanding want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
